// File: rtl/sample_az_ctrl.sv
// Auto-zero sample sequencer: mux select, precharge, settle, ADC trigger/handshake, sample stamping.
// Optional debug bus enabled by defining SAMPLE_AZ_CTRL_MONITOR_EN; otherwise monitor is tied to zero.
module sample_az_ctrl #(
  parameter int unsigned SETTLE_W       = 24,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd20_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                az_mode,
  input  logic [3:0]          azmux_hi_val,
  input  logic [3:0]          azmux_lo_val,
  input  logic [SETTLE_W-1:0] settle_cycles,
  input  logic                adc_measure_valid,
  output logic [3:0]          azmux,
  output logic                pc_switch,
  output logic                adc_measure_trig,
  output logic                sample_valid,
  output logic                sample_was_hi,
  output logic [31:0]         sample_count,
  output logic                timeout_err,
  output logic [7:0]          monitor
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETTLE   = 3'd1,
    S_TRIG     = 3'd2,
    S_ARMWAIT  = 3'd3,
    S_CONVWAIT = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                phase_hi_q, phase_hi_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [31:0]         tmo_cnt_q, tmo_cnt_d;
  logic                arm_seen_q, arm_seen_d;
  logic                timeout_hit;

  logic [3:0]          azmux_q, azmux_d;
  logic                pc_switch_q, pc_switch_d;
  logic                trig_q, trig_d;
  logic                sample_valid_q, sample_valid_d;
  logic                sample_was_hi_q, sample_was_hi_d;
  logic [31:0]         sample_count_q, sample_count_d;
  logic                timeout_err_q, timeout_err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      phase_hi_q      <= 1'b1;
      settle_cnt_q    <= '0;
      tmo_cnt_q       <= '0;
      arm_seen_q      <= 1'b0;
      azmux_q         <= 4'b0000;
      pc_switch_q     <= 1'b0;
      trig_q          <= 1'b0;
      sample_valid_q  <= 1'b0;
      sample_was_hi_q <= 1'b0;
      sample_count_q  <= '0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_hi_q      <= phase_hi_d;
      settle_cnt_q    <= settle_cnt_d;
      tmo_cnt_q       <= tmo_cnt_d;
      arm_seen_q      <= arm_seen_d;
      azmux_q         <= azmux_d;
      pc_switch_q     <= pc_switch_d;
      trig_q          <= trig_d;
      sample_valid_q  <= sample_valid_d;
      sample_was_hi_q <= sample_was_hi_d;
      sample_count_q  <= sample_count_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_hi_d   = phase_hi_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    arm_seen_d   = arm_seen_q;
    timeout_hit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d      = S_SETTLE;
          settle_cnt_d = settle_cycles;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = S_TRIG;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end
      S_TRIG: begin
        tmo_cnt_d  = TIMEOUT_CYCLES;
        arm_seen_d = 1'b0;
        state_d    = S_ARMWAIT;
      end
      S_ARMWAIT: begin
        if (tmo_cnt_q != '0) begin
          tmo_cnt_d = tmo_cnt_q - 32'd1;
        end
        // A stale valid is tolerated for at most two cycles; the ADC drops it by then.
        if (!adc_measure_valid || arm_seen_q) begin
          state_d = S_CONVWAIT;
        end else begin
          arm_seen_d = 1'b1;
        end
      end
      S_CONVWAIT: begin
        if (adc_measure_valid) begin
          state_d = S_DONE;
        end else if (tmo_cnt_q == '0) begin
          timeout_hit = 1'b1;
          state_d     = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q - 32'd1;
        end
      end
      S_DONE: begin
        phase_hi_d = az_mode ? ~phase_hi_q : 1'b1;
        if (run) begin
          state_d      = S_SETTLE;
          settle_cnt_d = settle_cycles;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d == S_IDLE) begin
      phase_hi_d = 1'b1;
    end
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    azmux_d         = azmux_lo_val;
    pc_switch_d     = 1'b0;
    if (state_d != S_IDLE) begin
      azmux_d     = phase_hi_d ? azmux_hi_val : azmux_lo_val;
      pc_switch_d = phase_hi_d;
    end
    trig_d          = (state_d == S_TRIG);
    sample_valid_d  = (state_d == S_DONE);
    sample_was_hi_d = sample_was_hi_q;
    sample_count_d  = sample_count_q;
    if (state_d == S_DONE) begin
      sample_was_hi_d = phase_hi_d;
      sample_count_d  = sample_count_q + 32'd1;
    end
    timeout_err_d   = timeout_err_q | timeout_hit;
  end

  assign azmux            = azmux_q;
  assign pc_switch        = pc_switch_q;
  assign adc_measure_trig = trig_q;
  assign sample_valid     = sample_valid_q;
  assign sample_was_hi    = sample_was_hi_q;
  assign sample_count     = sample_count_q;
  assign timeout_err      = timeout_err_q;

`ifdef SAMPLE_AZ_CTRL_MONITOR_EN
  logic [7:0] monitor_q, monitor_d;

  always_comb begin
    monitor_d = {sample_valid_d, 3'(state_d), phase_hi_d, pc_switch_d,
                 adc_measure_valid, trig_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      monitor_q <= 8'h00;
    end else begin
      monitor_q <= monitor_d;
    end
  end

  assign monitor = monitor_q;
`else
  assign monitor = 8'h00;
`endif

endmodule
